// File: rtl/fht_input_loader_if.sv
// Sample-in handshake and bank write bus of the FHT input loader.
// Ports: iDATA/iVALID/oREADY (sample stream), oDATA_WR/oADDR_WR/oWE (bank write).
interface fht_input_loader_if #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 9
);
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic [D_BIT-1:0] oDATA_WR;
    logic [A_BIT-1:0] oADDR_WR;
    logic [3:0]       oWE;

    modport master (
        output iDATA,
        output iVALID,
        input  oREADY,
        input  oDATA_WR,
        input  oADDR_WR,
        input  oWE
    );

    modport slave (
        input  iDATA,
        input  iVALID,
        output oREADY,
        output oDATA_WR,
        output oADDR_WR,
        output oWE
    );
endinterface

// File: rtl/fht_input_loader.sv
// FHT input stage: writes N samples bit-reversed into 4 banks, then kicks fht_control.
// Ports: iCLK, iRESET (async low), bus (sample/bank bus), oFHT_START, iFHT_RDY, oOVF, oBUSY.
module fht_input_loader #(
    parameter int N_BIT = 11,
    parameter int A_BIT = 9,
    parameter int D_BIT = 16
) (
    input  logic              iCLK,
    input  logic              iRESET,
    fht_input_loader_if.slave bus,
    output logic              oFHT_START,
    input  logic              iFHT_RDY,
    output logic              oOVF,
    output logic              oBUSY
);
    typedef enum logic [1:0] {
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [N_BIT-1:0] LAST = '1;

    state_t           state;
    state_t           stateNext;
    logic [N_BIT-1:0] cnt;
    logic [N_BIT-1:0] rev;
    logic             xfer;
    logic             lastXfer;
    logic             readyQ;
    logic             startQ;
    logic             ovfQ;
    logic [3:0]       weQ;
    logic [A_BIT-1:0] addrQ;
    logic [D_BIT-1:0] dataQ;

    // Low two bits of the reversed index pick the bank, the rest the word.
    always_comb begin
        rev = '0;
        for (int i = 0; i < N_BIT; i++) begin
            rev[i] = cnt[N_BIT-1-i];
        end
    end

    assign xfer     = bus.iVALID & readyQ;
    assign lastXfer = xfer & (cnt == LAST);

    always_comb begin
        stateNext = state;
        unique case (state)
            LOAD:      if (lastXfer) stateNext = KICK;
            KICK:      stateNext = WAIT_BUSY;
            WAIT_BUSY: if (!iFHT_RDY) stateNext = WAIT_DONE;
            WAIT_DONE: if (iFHT_RDY) stateNext = LOAD;
            default:   stateNext = LOAD;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state  <= LOAD;
            cnt    <= '0;
            readyQ <= 1'b1;
            startQ <= 1'b0;
            ovfQ   <= 1'b0;
            weQ    <= '0;
            addrQ  <= '0;
            dataQ  <= '0;
        end else begin
            state  <= stateNext;
            readyQ <= (stateNext == LOAD);
            // Registered so the pulse lands after the last bank write.
            startQ <= (state == KICK);
            weQ    <= '0;
            if (xfer) begin
                cnt   <= cnt + 1'b1;
                dataQ <= bus.iDATA;
                addrQ <= rev[N_BIT-1:2];
                weQ   <= 4'b0001 << rev[1:0];
            end
            if (bus.iVALID && !readyQ) begin
                ovfQ <= 1'b1;
            end
        end
    end

    assign bus.oREADY   = readyQ;
    assign bus.oDATA_WR = dataQ;
    assign bus.oADDR_WR = addrQ;
    assign bus.oWE      = weQ;
    assign oFHT_START   = startQ;
    assign oOVF         = ovfQ;
    assign oBUSY        = (state != LOAD);
endmodule
